// File: rtl/late1_rx.sv
// late1_rx: 8N1 UART receiver with a one-cycle registered input stage.
// The serial line is registered once (rx_q) and the FSM only ever looks at
// that delayed copy. The last good byte is held on rx_data.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a low level on rx_q
// ST_START     | start bit seen, re-checking it at mid-bit
// ST_DATA      | sampling data bits, one every CLKS_PER_BIT clocks, LSB first
// ST_STOP      | sampling the stop bit; a high level publishes the byte
// ST_WAIT_IDLE | framing error, waiting for the line to return high
module late1_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 wr_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam int CW = 16;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // The counter runs 0..C-1. The start bit is re-checked at count H, which
  // puts every later sample close to the middle of its bit.
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_rx_q;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   w_load;

  // Input stage: the FSM sees the line one clock late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_q <= 1'b1;
    else      r_rx_q <= rx;
  end

  // State, counters, shift register and output byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      if (w_load) r_rx_data <= r_shift;
    end
  end

  // Next-state logic. The byte is complete before ST_STOP is entered, so
  // the output loads directly from the shift register on a good stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!r_rx_q) w_state_nxt = ST_START;
      end

      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rx_q ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_rx_q;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_q) begin
            w_state_nxt = ST_IDLE;
            w_load      = wr_en;
          end else begin
            w_state_nxt = ST_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (r_rx_q) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    // Disabling the receiver abandons any frame in progress.
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_load      = 1'b0;
    end
  end

  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_late1_rx.sv
// tb_late1_rx: directed frames with hand-computed expected bytes.
module tb_late1_rx;

  localparam int C = 16;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic       rx;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  late1_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .wr_en   (wr_en),
    .rx      (rx),
    .rx_data (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the last edge of the
  // stop bit with rx still at the stop level. With timing set, rx_data is
  // checked one edge before and just after the stop-bit sample edge, which
  // falls on the 10th edge of the stop bit (rx_q lag + mid-bit start check).
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input logic timing, input logic [7:0] old_v,
                            input logic [7:0] new_v);
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = stop_val;
    for (int i = 1; i <= C; i++) begin
      @(posedge clk);
      #1;
      if (timing && i == 9)  check_eq("t2_before_stop_sample", rx_data, old_v);
      if (timing && i == 10) check_eq("t2_after_stop_sample", rx_data, new_v);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    wr_en  = 1'b0;
    rx     = 1'b1;

    // T1: reset held while rx toggles
    for (int i = 0; i < 10; i++) begin
      rx = ~rx;
      @(posedge clk);
      #1;
    end
    check_eq("t1_in_reset", rx_data, 8'h00);
    rx  = 1'b1;
    rst = 1'b1;
    idle(20);
    check_eq("t1_after_reset", rx_data, 8'h00);

    // T2: good frame with exact update timing
    enable = 1'b1;
    wr_en  = 1'b1;
    send_frame(8'h99, 1'b1, 1'b1, 8'h00, 8'h99);
    idle(5);
    check_eq("t2_frame_99", rx_data, 8'h99);

    // T3: wr_en gates the output only
    wr_en = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    check_eq("t3_wr_en_low_hold", rx_data, 8'h99);
    wr_en = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    check_eq("t3_frame_a5", rx_data, 8'hA5);

    // T4: 4-clock glitch is rejected at the mid-bit check
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(300);
    check_eq("t4_glitch_reject", rx_data, 8'hA5);

    // T5: framing error, then line held low
    send_frame(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (40) @(posedge clk);
    #1;
    check_eq("t5_framing_low", rx_data, 8'hA5);
    idle(400);
    check_eq("t5_after_release", rx_data, 8'hA5);

    // T6: enable dropped during data bit 3 of an all-ones-looking frame
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * C + 3) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b1;
    idle(300);
    check_eq("t6_abort_dropped", rx_data, 8'hA5);
    send_frame(8'h0F, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    check_eq("t6_frame_0f", rx_data, 8'h0F);

    // Back-to-back frames with no idle gap
    send_frame(8'h12, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("b2b_first_12", rx_data, 8'h12);
    send_frame(8'h34, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("b2b_second_34", rx_data, 8'h34);
    idle(5);

    // Reset mid-frame clears rx_data immediately, then receiver recovers
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_frame", rx_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(20);
    send_frame(8'h42, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    check_eq("rst_recover_42", rx_data, 8'h42);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
